// File: rtl/eth_tx_fcs_insert.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_fcs_insert
//  Purpose  : Ethernet transmit FCS inserter. Payload bytes are passed
//             straight through to the MAC with zero latency while being fed
//             (bit-reversed) to an external CRC-32 engine. After the last
//             payload byte (and optional zero padding) the CRC register is
//             captured in a single idle cycle, then emitted as four
//             complemented, bit-reversed FCS bytes.
//  Macro    : ETH_TX_PAD_EN - when defined, frames shorter than MIN_LEN bytes
//             are zero-padded up to MIN_LEN before the FCS. When undefined
//             there is no padding and MIN_LEN has no effect.
//  Ports    : i_sys_clk, i_rstn (async, active-low)
//             i_tx_data/i_tx_valid/i_tx_last/o_tx_ready : upstream byte stream
//             o_crc_data/o_crc_en/o_crc_done/i_fcs       : CRC-32 engine
//             o_mac_data/o_mac_valid/o_mac_last/i_mac_ready : MAC byte stream
//  Revision : 1.0 - initial release
// ============================================================================
module eth_tx_fcs_insert #(
    parameter int unsigned MIN_LEN = 60
) (
    input  logic        i_sys_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_tx_data,
    input  logic        i_tx_valid,
    input  logic        i_tx_last,
    output logic        o_tx_ready,
    output logic [7:0]  o_crc_data,
    output logic        o_crc_en,
    output logic        o_crc_done,
    input  logic [31:0] i_fcs,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_valid,
    output logic        o_mac_last,
    input  logic        i_mac_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
`ifdef ETH_TX_PAD_EN
        PAD  = 3'd2,
`endif
        CAPT = 3'd3,
        FCS  = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  count;
    logic [1:0]  k;
    logic [31:0] fcs_reg;

    logic [5:0]  count_base;
    logic [5:0]  count_next;
    logic [7:0]  fcs_byte;
    logic        accept;
    state_t      exit_state;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Counter is cleared while idle, so the first byte of a frame counts as 1.
    assign count_base = (state == IDLE) ? 6'd0 : count;
    assign count_next = (count_base == 6'd63) ? 6'd63 : count_base + 6'd1;

    always_comb begin
        fcs_byte = 8'h00;
        case (k)
            2'd0: fcs_byte = ~bitrev8(fcs_reg[31:24]);
            2'd1: fcs_byte = ~bitrev8(fcs_reg[23:16]);
            2'd2: fcs_byte = ~bitrev8(fcs_reg[15:8]);
            2'd3: fcs_byte = ~bitrev8(fcs_reg[7:0]);
            default: fcs_byte = 8'h00;
        endcase
    end

`ifdef ETH_TX_PAD_EN
    localparam logic [5:0] MIN_LEN_C = MIN_LEN[5:0];
    assign exit_state = (count_next < MIN_LEN_C) ? PAD : CAPT;
`else
    logic unused_min_len;
    assign unused_min_len = ^MIN_LEN[5:0];
    assign exit_state     = CAPT;
`endif

    // Outputs are decoded from state so payload passes through with no
    // added latency; reset gating keeps the MAC side quiet while i_rstn is low.
    always_comb begin
        o_tx_ready  = 1'b0;
        o_mac_valid = 1'b0;
        o_mac_data  = 8'h00;
        o_mac_last  = 1'b0;
        o_crc_done  = 1'b0;
        if (i_rstn) begin
            case (state)
                IDLE, DATA: begin
                    o_tx_ready  = i_mac_ready;
                    o_mac_valid = i_tx_valid;
                    o_mac_data  = i_tx_data;
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    o_mac_valid = 1'b1;
                    o_mac_data  = 8'h00;
                end
`endif
                CAPT: begin
                    o_crc_done = 1'b1;
                end
                FCS: begin
                    o_mac_valid = 1'b1;
                    o_mac_data  = fcs_byte;
                    o_mac_last  = (k == 2'd3);
                end
                default: begin
                    o_tx_ready = 1'b0;
                end
            endcase
        end
    end

    // Payload and pad bytes feed the CRC; FCS bytes do not.
    assign accept     = o_mac_valid & i_mac_ready & (state != FCS);
    assign o_crc_en   = accept;
    assign o_crc_data = bitrev8(o_mac_data);

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= IDLE;
            count   <= 6'd0;
            k       <= 2'd0;
            fcs_reg <= 32'd0;
        end else begin
            case (state)
                IDLE, DATA: begin
                    if (state == IDLE) begin
                        count <= 6'd0;
                    end
                    if (accept) begin
                        count <= count_next;
                        state <= i_tx_last ? exit_state : DATA;
                    end
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    if (accept) begin
                        count <= count_next;
                        if (count_next == MIN_LEN_C) begin
                            state <= CAPT;
                        end
                    end
                end
`endif
                CAPT: begin
                    fcs_reg <= i_fcs;
                    k       <= 2'd0;
                    state   <= FCS;
                end
                FCS: begin
                    if (i_mac_ready) begin
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
